// File: rtl/wb_commit_unit_pkg.sv
// Shared constants, the buffered write-back entry type and the index decoder
// used by the write-back commit unit.
package wb_commit_unit_pkg;

    localparam int DW    = 8;
    localparam int NREG  = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wb_entry_t;

    // Indices beyond the register count decode to no select at all.
    function automatic logic [NREG-1:0] onehot_decode(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        if (int'(idx) < NREG) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// Upstream request, register-file write and operand read signals of the
// write-back commit unit, bundled with the unit as slave.
interface wb_commit_unit_if;
    import wb_commit_unit_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_dest;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] wr_select;
    logic [AW-1:0]   rd_sel1;
    logic [AW-1:0]   rd_sel2;
    logic [DW-1:0]   rf_out1;
    logic [DW-1:0]   rf_out2;
    logic [DW-1:0]   op1;
    logic [DW-1:0]   op2;
    logic            idle;

    modport master (
        output in_valid, in_dest, in_data, rd_sel1, rd_sel2, rf_out1, rf_out2,
        input  in_ready, wr_data, wr_select, op1, op2, idle
    );

    modport slave (
        input  in_valid, in_dest, in_data, rd_sel1, rd_sel2, rf_out1, rf_out2,
        output in_ready, wr_data, wr_select, op1, op2, idle
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending write-back entries with wrapping pointers,
// exposing every entry in age order (tap 0 = oldest) for operand forwarding.
module wb_fifo
    import wb_commit_unit_pkg::*;
#(
    parameter int N = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  wb_entry_t              i_entry,
    input  logic                   i_pop,
    output wb_entry_t              o_head,
    output logic [$clog2(N+1)-1:0] o_count,
    output logic [N-1:0]           o_tap_v,
    output wb_entry_t              o_tap [N]
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(N+1);

    wb_entry_t     r_mem [N];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; r_count alone decides what is live.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    for (genvar g = 0; g < N; g++) begin : g_tap
        logic [PW-1:0] w_idx;
        assign w_idx      = PW'((int'(r_rd_ptr) + g) % N);
        assign o_tap_v[g] = (int'(r_count) > g);
        assign o_tap[g]   = r_mem[w_idx];
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back stage ahead of the working register file: buffers results, commits
// one per cycle on a falling-edge launched write select, and forwards pending data.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
(
    input logic            clk,
    input logic            reset,
    wb_commit_unit_if.slave bus
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_pop;
    wb_entry_t        w_in_entry;
    wb_entry_t        w_head;
    logic [DEPTH-1:0] w_tap_v;
    wb_entry_t        w_tap [DEPTH];

    logic             r_cm_v;
    logic [AW-1:0]    r_cm_dest;
    logic [DW-1:0]    r_cm_data;
    logic [NREG-1:0]  r_wr_select;
    logic [DW-1:0]    r_wr_data;

    logic [AW-1:0]    w_sel [2];
    logic [DW-1:0]    w_rf  [2];
    logic [DW-1:0]    w_op  [2];

    assign bus.in_ready = (int'(w_count) < DEPTH);
    assign w_push       = bus.in_valid & bus.in_ready;
    // Pop decision uses registered count, so an entry pushed into an empty
    // buffer is only committed on the following edge.
    assign w_pop        = (w_count != '0);
    assign w_in_entry   = {bus.in_dest, bus.in_data};

    wb_fifo #(
        .N (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_in_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_tap_v (w_tap_v),
        .o_tap   (w_tap)
    );

    // Commit stage: rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cm_v    <= 1'b0;
            r_cm_dest <= '0;
            r_cm_data <= '0;
        end else begin
            r_cm_v <= w_pop;
            if (w_pop) begin
                r_cm_dest <= w_head.dest;
                r_cm_data <= w_head.data;
            end
        end
    end

    // Drive stage: falling edge, so the select is settled for the whole
    // clk-high phase in which the register file gates it with clk.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_select <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_select <= r_cm_v ? onehot_decode(r_cm_dest) : '0;
            r_wr_data   <= r_cm_data;
        end
    end

    assign bus.wr_select = r_wr_select;
    assign bus.wr_data   = r_wr_data;

    assign w_sel[0] = bus.rd_sel1;
    assign w_sel[1] = bus.rd_sel2;
    assign w_rf[0]  = bus.rf_out1;
    assign w_rf[1]  = bus.rf_out2;

    // Sources applied oldest-first so each later match overrides: register
    // file, drive stage, commit stage, then FIFO entries oldest to newest.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_op[p] = w_rf[p];
            if (r_wr_select[w_sel[p]]) w_op[p] = r_wr_data;
            if (r_cm_v && (r_cm_dest == w_sel[p])) w_op[p] = r_cm_data;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_tap_v[i] && (w_tap[i].dest == w_sel[p])) w_op[p] = w_tap[i].data;
            end
        end
    end

    assign bus.op1  = w_op[0];
    assign bus.op2  = w_op[1];
    assign bus.idle = (w_count == '0) & ~r_cm_v & (r_wr_select == '0);

endmodule
